// File: rtl/apb_regfile_slave.sv
// APB3 register-file slave: NUM_REGS word registers, programmable wait states,
// decode/protocol error reporting. Define APB_PSTRB_EN to add the PSTRB byte-lane port.
module apb_regfile_slave #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(NUM_BYTES);
  localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0]            WAIT_LIM   = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_SETUP  = 3'b010,
    S_ACCESS = 3'b100
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   row_d;
  logic [ADDR_WIDTH-1:0]   word_addr_s;
  logic [IDX_W-1:0]        reg_idx_s;
  logic [NUM_BYTES-1:0]    wr_strb_s;
  logic                    dec_err_s;
  logic                    proto_err_s;
  logic                    wr_en_s;

  assign word_addr_s = PADDR >> OFF_W;
  assign reg_idx_s   = word_addr_s[IDX_W-1:0];
  assign dec_err_s   = (word_addr_s >= NUM_REGS_A) || ((PADDR & OFF_MASK) != '0);
  // An ACCESS-phase strobe seen while the FSM never left IDLE means SETUP was skipped.
  assign proto_err_s = PSEL && PENABLE && (state_q == S_IDLE);
  assign wr_en_s     = PREADY && PWRITE && !PSLVERR;

`ifdef APB_PSTRB_EN
  assign wr_strb_s = PSTRB;
`else
  assign wr_strb_s = '1;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d    = S_IDLE;
    wait_cnt_d = wait_cnt_q;
    if (!PSEL) begin
      state_d = S_IDLE;
    end else if (!PENABLE) begin
      state_d = S_SETUP;
    end else if (!PREADY) begin
      state_d = S_ACCESS;
    end else begin
      state_d = S_IDLE;
    end

    if (!PSEL || PREADY) begin
      wait_cnt_d = 4'd0;
    end else if (PENABLE) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Reset forces every response output low, even for an otherwise erroneous strobe.
  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = '0;
    if (!PRESET && PSEL && PENABLE) begin
      PREADY  = proto_err_s || (wait_cnt_q == WAIT_LIM);
      PSLVERR = PREADY && (dec_err_s || proto_err_s);
      if (PREADY && !PWRITE && !PSLVERR) begin
        PRDATA = regs_q[reg_idx_s];
      end else begin
        PRDATA = '0;
      end
    end else begin
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
    end
  end

  always_comb begin
    row_d = regs_q[reg_idx_s];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wr_strb_s[b]) begin
        row_d[8*b +: 8] = PWDATA[8*b +: 8];
      end else begin
        row_d[8*b +: 8] = regs_q[reg_idx_s][8*b +: 8];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else if (wr_en_s) begin
      regs_q[reg_idx_s] <= row_d;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomized self-checking bench for apb_regfile_slave against an array-based register model.
module tb_apb_regfile_slave;

  localparam int          NR = 16;
  localparam int          WS = 2;
  localparam logic [31:0] RV = 32'hA5A5_0F0F;

  logic        PCLK = 1'b0;
  logic        PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
`ifdef APB_PSTRB_EN
  logic [3:0]  PSTRB;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NR];

  always #5 PCLK = ~PCLK;

  apb_regfile_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (NR),
    .WAIT_STATES(WS),
    .RESET_VAL  (RV)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
`ifdef APB_PSTRB_EN
    .PSTRB  (PSTRB),
`endif
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  function automatic bit exp_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(NR));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model[i] = RV;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    logic [3:0] s;
`ifdef APB_PSTRB_EN
    s = strb;
`else
    s = 4'hF;
`endif
    if (!exp_err(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // Caller is at posedge+1; leaves the bus idle at posedge+1 after completion.
  task automatic apb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic err, output int waits);
    bit done;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
`ifdef APB_PSTRB_EN
    PSTRB = strb;
`endif
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0; done = 1'b0; rdata = 32'h0; err = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL pready_timeout: addr %h got no PREADY, required PREADY within 40 cycles", a);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic idle_cycle();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int w;
    PRESET = 1'b1; PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
    PADDR = 32'h0; PWDATA = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge PCLK);
      checks++;
      if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
        errors++;
        $display("FAIL reset_outputs: got rdy=%b err=%b rdata=%h, required all 0", PREADY, PSLVERR, PRDATA);
      end
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    idle_cycle();
    for (int i = 0; i < NR; i++) begin
      apb_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, w);
      checks++;
      if (rd !== RV || er !== 1'b0) begin
        errors++;
        $display("FAIL reset_value[%0d]: got %h err=%b, required %h err=0", i, rd, er, RV);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int w;
    apb_xfer(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, rd, er, w);
    model_write(32'h08, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (w !== WS || er !== 1'b0 || rd !== 32'h0) begin
      errors++;
      $display("FAIL wait_write: got waits=%0d err=%b rdata=%h, required waits=%0d err=0 rdata=0", w, er, rd, WS);
    end
    apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (w !== WS || er !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wait_read: got waits=%0d err=%b rdata=%h, required waits=%0d err=0 rdata=deadbeef", w, er, rd, WS);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int w;
    apb_xfer(1'b1, 32'h40, 32'h1234_5678, 4'hF, rd, er, w);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_range_write: got pslverr=%b, required 1", er);
    end
    apb_xfer(1'b1, 32'h05, 32'h8765_4321, 4'hF, rd, er, w);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL err_align_write: got pslverr=%b, required 1", er);
    end
    apb_xfer(1'b0, 32'h0A, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_read: got pslverr=%b rdata=%h, required 1 and 0", er, rd);
    end
    for (int i = 0; i < NR; i++) begin
      apb_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, w);
      checks++;
      if (rd !== model[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL err_unchanged[%0d]: got %h err=%b, required %h err=0", i, rd, er, model[i]);
      end
    end
  endtask

  task automatic test_protocol();
    logic [31:0] rd; logic er; int w;
    for (int k = 0; k < 2; k++) begin
      idle_cycle();
      PSEL = 1'b1; PENABLE = 1'b1; PWRITE = (k == 0); PADDR = 32'h08; PWDATA = 32'h1357_9BDF;
      @(negedge PCLK);
      checks++;
      if (PREADY !== 1'b1 || PSLVERR !== 1'b1 || PRDATA !== 32'h0) begin
        errors++;
        $display("FAIL protocol_err[%0d]: got rdy=%b err=%b rdata=%h, required 1 1 0", k, PREADY, PSLVERR, PRDATA);
      end
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
    end
    apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== model[2] || er !== 1'b0) begin
      errors++; $display("FAIL protocol_nowrite: got %h err=%b, required %h err=0", rd, er, model[2]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, rd, exp_rd; logic er, exp_e; int w; bit wr; logic [3:0] s;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 7) a = 32'($urandom_range(0, NR - 1)) << 2;
      else                          a = 32'($urandom_range(0, 127));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      exp_e  = exp_err(a);
      exp_rd = (!wr && !exp_e) ? model[a[5:2]] : 32'h0;
      apb_xfer(wr, a, d, s, rd, er, w);
      if (wr) model_write(a, d, s);
      checks++;
      if (er !== exp_e) begin
        errors++; $display("FAIL rand_err[%0d]: addr %h got %b, required %b", n, a, er, exp_e);
      end
      checks++;
      if (rd !== exp_rd) begin
        errors++; $display("FAIL rand_rdata[%0d]: addr %h got %h, required %h", n, a, rd, exp_rd);
      end
      checks++;
      if (w !== WS) begin
        errors++; $display("FAIL rand_waits[%0d]: got %0d, required %0d", n, w, WS);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd; logic er; int w;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'h0BAD_F00D;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    checks++;
    if (PREADY !== 1'b0) begin
      errors++; $display("FAIL mid_first_wait: got PREADY=%b, required 0", PREADY);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got rdy=%b err=%b rdata=%h, required all 0", PREADY, PSLVERR, PRDATA);
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    idle_cycle();
    for (int i = 0; i < NR; i++) begin
      apb_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, w);
      checks++;
      if (rd !== model[i] || er !== 1'b0 || w !== WS) begin
        errors++;
        $display("FAIL mid_after_reset[%0d]: got %h err=%b waits=%0d, required %h err=0 waits=%0d", i, rd, er, w, model[i], WS);
      end
    end
    apb_xfer(1'b1, 32'h0C, 32'h600D_CAFE, 4'hF, rd, er, w);
    model_write(32'h0C, 32'h600D_CAFE, 4'hF);
    apb_xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== 32'h600D_CAFE || er !== 1'b0) begin
      errors++; $display("FAIL mid_next_xfer: got %h err=%b, required 600dcafe err=0", rd, er);
    end
  endtask

`ifdef APB_PSTRB_EN
  task automatic test_strobe();
    logic [31:0] rd; logic er; int w;
    apb_xfer(1'b1, 32'h00, 32'h1111_1111, 4'hF, rd, er, w);
    apb_xfer(1'b1, 32'h00, 32'hAABB_CCDD, 4'b0101, rd, er, w);
    apb_xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== 32'h11BB_11DD) begin
      errors++; $display("FAIL strobe_merge: got %h, required 11bb11dd", rd);
    end
    apb_xfer(1'b1, 32'h00, 32'hFFFF_FFFF, 4'h0, rd, er, w);
    checks++;
    if (er !== 1'b0 || w !== WS) begin
      errors++; $display("FAIL strobe_zero_done: got err=%b waits=%0d, required 0 and %0d", er, w, WS);
    end
    apb_xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== 32'h11BB_11DD) begin
      errors++; $display("FAIL strobe_zero_keep: got %h, required 11bb11dd", rd);
    end
    model[0] = 32'h11BB_11DD;
  endtask
`endif

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0;
`ifdef APB_PSTRB_EN
    PSTRB = 4'h0;
`endif
    test_reset();
    test_wait_states();
    test_errors();
    test_protocol();
`ifdef APB_PSTRB_EN
    test_strobe();
`endif
    test_random();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, PWDATA/PRDATA width; SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, PADDR width.
REQ-003 The block SHALL have parameter NUM_REGS, default 16, register count; SHALL be 2..256.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0, PREADY-low cycles inserted per ACCESS; SHALL be 0..15.
REQ-005 The block SHALL have parameter RESET_VAL, default 0, reset value of every register.
REQ-006 The block SHALL have port PCLK, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-007 The block SHALL have port PRESET, input, 1, reset; synchronous and active-high.
REQ-008 The block SHALL have port PSEL, input, 1, slave select.
REQ-009 The block SHALL have port PENABLE, input, 1, access phase strobe.
REQ-010 The block SHALL have port PWRITE, input, 1; 1 = write, 0 = read.
REQ-011 The block SHALL have port PADDR, input, ADDR_WIDTH, byte address.
REQ-012 The block SHALL have port PWDATA, input, DATA_WIDTH, write data.
REQ-013 The block SHALL have port PRDATA, output, DATA_WIDTH, read data.
REQ-014 The block SHALL have port PREADY, output, 1, transfer completion.
REQ-015 The block SHALL have port PSLVERR, output, 1, transfer error; valid only while PREADY=1.

Function
REQ-016 The phase FSM SHALL be one-hot: IDLE=3'b001, SETUP=3'b010, ACCESS=3'b100.
REQ-017 Next state SHALL be IDLE when PSEL=0; SETUP when PSEL=1 and PENABLE=0; ACCESS when PSEL=1, PENABLE=1 and PREADY=0; IDLE when PSEL=1, PENABLE=1 and PREADY=1.
REQ-018 wait_cnt (4 bits) SHALL increment each cycle with PSEL=1, PENABLE=1, PREADY=0, and SHALL clear on the cycle with PREADY=1 or PSEL=0.
REQ-019 PREADY SHALL be combinational: PSEL & PENABLE & (wait_cnt == WAIT_STATES); WAIT_STATES=0 gives a zero-wait ACCESS.
REQ-020 Register index SHALL be PADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)].
REQ-021 Decode error SHALL be index >= NUM_REGS or PADDR low byte-offset bits nonzero.
REQ-022 Protocol error SHALL be PSEL=1 and PENABLE=1 while the state register is IDLE, i.e. no preceding SETUP.
REQ-023 On a protocol error, PREADY SHALL assert in that cycle regardless of wait_cnt.
REQ-024 PSLVERR SHALL equal PREADY & (decode error | protocol error).
REQ-025 A write SHALL commit at the rising edge ending a cycle with PREADY=1, PWRITE=1 and PSLVERR=0.
REQ-026 An errored write SHALL not modify any register.
REQ-027 PRDATA SHALL be regs[index] when PREADY=1, PWRITE=0 and PSLVERR=0; otherwise PRDATA SHALL be 0.
REQ-028 Back-to-back transfers, with a new SETUP in the cycle after completion, SHALL be supported with no idle cycle.
REQ-029 A read in the cycle after a write to the same register SHALL return the new value.

Reset
REQ-030 When PRESET=1 at a rising edge, state SHALL go to IDLE, wait_cnt to 0 and every register to RESET_VAL.
REQ-031 PRESET SHALL take priority over any in-flight write, which SHALL not commit.
REQ-032 While PRESET=1, PREADY, PSLVERR and PRDATA SHALL be 0.
REQ-033 PRESET asserted during ACCESS SHALL abort the transfer; the next transfer SHALL begin with a fresh SETUP.

Configuration
REQ-034 With APB_PSTRB_EN defined, the block SHALL have port PSTRB, input, DATA_WIDTH/8, and a write SHALL update only bytes whose PSTRB bit is 1.
REQ-035 With APB_PSTRB_EN defined, PSTRB=0 SHALL complete normally with no register change.
REQ-036 With APB_PSTRB_EN not defined, PSTRB SHALL be absent and every write SHALL update all bytes.

Verification
REQ-037 Reset: PRESET=1 for 2 cycles, then read every index -> PRDATA=RESET_VAL, PSLVERR=0.
REQ-038 Wait states: WAIT_STATES=2; write 32'hDEAD_BEEF to 0x08, then read 0x08 -> PREADY low 2 ACCESS cycles, high on the 3rd; PRDATA=32'hDEAD_BEEF.
REQ-039 Errors: NUM_REGS=16; write 0x40, then write 0x05 -> PSLVERR=1 with PREADY=1 on both; all registers unchanged.
REQ-040 Protocol: PSEL=1 and PENABLE=1 from IDLE, PWRITE=1 -> PREADY=1, PSLVERR=1 same cycle; no write.
REQ-041 Strobe, with APB_PSTRB_EN: register 0x00=32'h1111_1111; write 32'hAABB_CCDD, PSTRB=4'b0101 -> read 32'h11BB_11DD.
REQ-042 Reset mid-ACCESS: WAIT_STATES=3; PRESET pulsed in 2nd wait cycle of a write -> target register stays RESET_VAL; the next transfer completes normally.
